// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Outputs are registered one cycle behind the scan index; frame_done pulses the cycle after each wrap.
// No backpressure: ld is always accepted. New data is double-buffered and shown from the next frame start.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits of the committed word.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [31:0] val,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  a2g,
  output logic        dp,
  output logic        frame_done,
  output logic [2:0]  cur_digit
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic             tick;
  logic             wrap;

  logic [31:0] sh_val;
  logic [7:0]  sh_en;
  logic [7:0]  sh_dp;
  logic        pending;

  logic [31:0] disp_val;
  logic [7:0]  disp_en;
  logic [7:0]  disp_dp;

  logic [7:0]  eff_en;
  logic [3:0]  nib;
  logic [7:0]  an_n;
  logic [6:0]  a2g_n;
  logic        dp_n;

  assign tick = (cnt == LAST);
  assign wrap = tick && (idx == 3'd7);

  // Active-low {a..g} hex segment patterns.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase
  endfunction

  // Prescaler and scan index: idx advances once per REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit; an ld in the wrap cycle bypasses the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val   <= '0;
      sh_en    <= '0;
      sh_dp    <= '0;
      pending  <= 1'b0;
      disp_val <= '0;
      disp_en  <= '0;
      disp_dp  <= '0;
    end else begin
      if (ld) begin
        sh_val <= val;
        sh_en  <= digit_en;
        sh_dp  <= dp_mask;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (ld) begin
          disp_val <= val;
          disp_en  <= digit_en;
          disp_dp  <= dp_mask;
        end else if (pending) begin
          disp_val <= sh_val;
          disp_en  <= sh_en;
          disp_dp  <= sh_dp;
        end
      end else if (ld) begin
        pending <= 1'b1;
      end
    end
  end

  // Effective per-digit enable, optionally suppressing leading zeros of the committed word.
  always_comb begin
    eff_en = disp_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 8; i++) begin
      if ((disp_val >> (4 * i)) == 32'd0) eff_en[i] = 1'b0;
    end
`else
    eff_en = disp_en;
`endif
  end

  // Next output pattern for the slot currently selected by idx.
  always_comb begin
    an_n  = 8'hFF;
    a2g_n = 7'h7F;
    dp_n  = 1'b1;
    nib   = disp_val[{idx, 2'b00} +: 4];
    if (eff_en[idx]) begin
      an_n[idx] = 1'b0;
      a2g_n     = hex_seg(nib);
      dp_n      = ~disp_dp[idx];
    end
  end

  // Registered output stage, one cycle behind idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 8'hFF;
      a2g        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      cur_digit  <= 3'd0;
    end else begin
      an         <= an_n;
      a2g        <= a2g_n;
      dp         <= dp_n;
      frame_done <= wrap;
      cur_digit  <= idx;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Sits directly downstream of the data-memory IO decoder, which presents a 32-bit display word plus digit/decimal-point masks with a load strobe.
- Shows one hex digit per refresh slot, scanning 0..7, with active-low an/a2g/dp outputs.
- Updates are double-buffered: new data is committed only at frame boundaries, so no torn frames.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range >=1. Gives 1 kHz per digit (125 Hz frame) at 100 MHz.
- DIV_W, 17: prescaler width; must satisfy 2^DIV_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld  in  1  load strobe; captures val, digit_en and dp_mask into the shadow registers
- val  in  32  display word; digit i shows val[4i+3:4i]
- digit_en  in  8  per-digit enable; 0 blanks that digit
- dp_mask  in  8  per-digit decimal point, 1 = lit
- an  out  8  anode selects, active-low
- a2g  out  7  segments {a,b,c,d,e,f,g} on a2g[6:0], active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame wrap
- cur_digit  out  3  index of the digit currently driven on an/a2g/dp

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-frame or mid-load):
  - prescaler=0, idx=0, pending=0; shadow and display registers=0.
  - Outputs: an=8'hFF, a2g=7'h7F, dp=1, frame_done=0, cur_digit=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle where count==REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index:
  - On tick, idx <= idx+1 mod 8.
  - wrap = tick && idx==7.
- Load path:
  - ld=1 at a clock edge: shadow <= {val,digit_en,dp_mask}, pending <= 1.
  - Back-to-back ld: the last value wins; only one commit occurs.
- Commit at wrap:
  - If pending=1: display <= shadow, pending <= 0.
  - If ld=1 in the same cycle: display <= the live inputs directly (bypass), pending <= 0.
  - No ld since the last commit: display unchanged.
- frame_done: registered; equals 1 for exactly one cycle, the cycle after each wrap.
- Output stage:
  - an/a2g/dp/cur_digit are registered from idx and the display registers, so they lag an idx change by exactly 1 cycle.
  - an: bit idx low only if display_en[idx]=1; all other bits high.
  - Blanked digit: a2g=7'h7F, dp=1.
  - Lit digit: a2g = hex decode of the nibble; dp = ~display_dp[idx].
- Hex decode (active-low, {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- No handshake back-pressure: ld is always accepted.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN
- Defined: the effective enable for digit i is forced to 0 when all nibbles i..7 of the display word are zero, for i>=1. Digit 0 follows digit_en[0] only. Evaluated on the committed display word.
- Undefined: every enabled digit is shown, including leading zeros.

Test Plan (REFRESH_DIV=4):
- Reset behaviour: assert reset mid-scan -> same cycle an=FF, a2g=7F, dp=1; after release, the first tick occurs 4 cycles later and idx advances 0->1.
- Basic display: ld with val=32'h76543210, digit_en=FF, dp_mask=01, then wait for a wrap -> next frame shows slot k with an=~(1<<k) and a2g=decode(k); dp=0 only in slot 0; frame period = 32 cycles; frame_done pulses once per 32 cycles.
- Tear-free update: ld val=32'hFFFFFFFF while idx=3 mid-frame -> slots 3..7 still show the old digits; the new value appears starting at slot 0 of the next frame.
- ld coincident with wrap: ld val=32'hA in the wrap cycle -> the following frame already shows A on digit 0 (bypass); pending=0 afterwards.
- Blanking: digit_en=8'h0F -> slots 4..7 give an=FF, a2g=7F. With SEG7_LEADING_ZERO_BLANK_EN and val=32'h00000050, digit_en=FF -> only digits 0 and 1 lit; val=0 -> only digit 0 lit, showing "0".
